// File: rtl/accel_mem_req_queue.sv
// accel_mem_req_queue: FIFO of accelerator memory requests sitting in front of
// the data-memory arbiter. The CPU always wins the memory port; the head entry
// is offered to the arbiter only in cycles where the CPU is idle. Read results
// come back one cycle after issue with a single-cycle valid strobe, and a
// starvation flag rises when the head has been blocked for STARVE_MAX cycles.
module accel_mem_req_queue #(
  parameter int DEPTH      = 4,   // power of two, at least 2
  parameter int STARVE_MAX = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  // accelerator request side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [15:0]              req_addr,
  input  logic [31:0]              req_wdata,
  // arbiter side
  input  logic                     cpu_busy,
  output logic [15:0]              mem_addr,
  output logic [31:0]              mem_wrt_data,
  output logic                     mem_wrt_en,
  output logic                     mem_rd_en,
  input  logic [511:0]             mem_rd_data,
  // response and status
  output logic                     rsp_valid,
  output logic [511:0]             rsp_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } entry_t;

  entry_t          fifo_mem [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            starve_q, starve_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            issue;
  entry_t          head;
  entry_t          new_entry;

  // Full/empty come from registered occupancy only, so a pop in the same
  // cycle never opens req_ready combinationally.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;

  // The head may go out only when the CPU leaves the port idle; an entry
  // pushed into an empty queue waits one cycle because count_q is still 0.
  assign head      = fifo_mem[rd_ptr_q];
  assign issue     = ~empty & ~cpu_busy;

  assign new_entry = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

  assign mem_addr     = empty ? 16'h0000 : head.addr;
  assign mem_wrt_data = empty ? 32'h0000_0000 : head.wdata;
  assign mem_rd_en    = issue & ~head.wr;
  assign mem_wrt_en   = issue & head.wr;

  // Read data is returned straight from memory; only the strobe is timed here.
  assign rsp_rdata = mem_rd_data;
  assign rsp_valid = rsp_valid_q;
  assign count     = count_q;
  assign starve    = starve_q;

  // Entry storage is data-only and needs no reset; pointers decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= new_entry;
    end
  end

  // Next-state for pointers, occupancy, response strobe and starvation.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_cnt_d = starve_cnt_q;
    rsp_valid_d  = issue & ~head.wr;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(issue);

    // Starvation counts blocked cycles of a pending head and restarts on
    // every successful issue or whenever the queue is empty.
    if (issue || empty) begin
      starve_cnt_d = '0;
    end else if (cpu_busy && (starve_cnt_q != SW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    starve_d = (starve_cnt_d == SW'(STARVE_MAX));
  end

  // State registers; reset discards queued entries and any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

endmodule

// File: doc/accel_mem_req_queue.md
Name: accel_mem_req_queue

Overview:
- Request buffer between the accelerator cluster and the data-memory arbiter; holds accelerator reads/writes while the CPU owns the memory port.
- Issues the head request on the arbiter's accelerator side only in cycles where the CPU is idle. Returns 512-bit read data with a valid strobe.
- Flags starvation when the CPU holds the port too long.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- STARVE_MAX, 64, consecutive blocked cycles with a pending head before starve asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  accelerator presents a request.
- req_ready  out  1  queue can accept; equals !full.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  16  word address.
- req_wdata  in  32  write data, ignored for reads.
- cpu_busy  in  1  CPU wrt_en OR rd_en this cycle; CPU has priority at the arbiter.
- mem_addr  out  16  accelerator address to arbiter.
- mem_wrt_data  out  32  accelerator write data to arbiter.
- mem_wrt_en  out  1  accelerator write strobe.
- mem_rd_en  out  1  accelerator read strobe.
- mem_rd_data  in  512  memory read data, valid one cycle after an accepted read.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read result.
- rsp_rdata  out  512  read result.
- count  out  $clog2(DEPTH)+1  current occupancy.
- starve  out  1  head blocked for at least STARVE_MAX cycles.

Behaviour:
- Reset (async, active-high): wr/rd pointers=0, count=0, starve=0, rsp_valid=0, starve counter=0. Storage contents don't care. Outputs: req_ready=1, mem_wrt_en=0, mem_rd_en=0.
- Storage: circular buffer of {wr, addr, wdata}, DEPTH entries. Pointers wrap modulo DEPTH.
- Push: req_valid & req_ready at posedge writes entry at wr_ptr; wr_ptr+1.
- req_ready = (count != DEPTH). It is registered-state only; there is no combinational path from pop.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Issue (combinational): issue = (count != 0) & !cpu_busy.
  - mem_rd_en = issue & !head.wr; mem_wrt_en = issue & head.wr.
  - mem_addr and mem_wrt_data always show the head entry. They are 0 when empty.
- Pop: on issue at posedge, rd_ptr+1.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged and is legal when not full.
- Empty queue with push: the entry cannot issue in its push cycle. Minimum latency is push at t, issue at t+1.
- Read response: rsp_valid is a flop set to (issue & !head.wr). rsp_rdata = mem_rd_data passed through combinationally.
  - Read issued in cycle t gives rsp_valid=1 in cycle t+1 with the data for that address.
  - Back-to-back reads give back-to-back rsp_valid pulses.
  - Writes produce no response.
- Ordering: strict FIFO. A read after a write to the same address returns the written value, because both go through the same queue.
- Starvation: counter increments each cycle with count!=0 & cpu_busy, saturating at STARVE_MAX. It clears to 0 on any pop or when empty.
  - starve = (counter == STARVE_MAX), registered. It deasserts the cycle after the pop.
- Reset mid-operation: queued entries are discarded; an in-flight rsp_valid is dropped.
- Overflow and underflow cannot occur by construction. A bench assertion checks that count never exceeds DEPTH.

Test Plan:
- Single read: cpu_busy=0; push read addr 0x0010 at t, where memory word 0x0010 = 0xDEADBEEF. Required: mem_rd_en=1 with mem_addr=0x0010 at t+1; rsp_valid=1 with rsp_rdata[31:0]=0xDEADBEEF at t+2; count returns to 0.
- CPU priority: push write (0x0020, 0x12345678) then read 0x0020 with cpu_busy=1 for 10 cycles. Required: no mem strobes and count=2 throughout; after cpu_busy falls, write then read issue on consecutive cycles; read returns 0x12345678.
- Full: cpu_busy=1; push 5 requests with DEPTH=4. Required: req_ready=0 after the 4th push, 5th held off, count=4; dropping cpu_busy drains entries in order 1..4 and the 5th is accepted once req_ready=1.
- Wrap: 10 alternating write/read pairs to addresses 0x0100..0x0109 with random cpu_busy. Required: every read returns its paired write data; pointers wrap with no loss.
- Starvation: one pending request, cpu_busy=1 for 70 cycles, STARVE_MAX=64. Required: starve=1 from the 65th blocked cycle, clears the cycle after issue.
- Reset mid-op: queue 3 entries plus a read in flight, assert rst for 1 cycle. Required: count=0, rsp_valid=0, no strobes, req_ready=1 immediately.
